// File: rtl/serial_controller.sv
// ---------------------------------------------------------------------------
// serial_controller
//
// UART responder for the CPU's serial I/O window. Transmit bytes are queued
// in a 4-entry FIFO and serialised onto txd (8N1, LSB first). Receive bytes
// are deserialised from rxd into a one-byte holding register with valid and
// overrun flags. Register reads return data combinationally in the same cycle.
//
// Register map (addr[3:0]):
//   0x8 DATA    write: push TX byte   read: {24'b0, rx_byte}, clears valid/overrun
//   0xC STATUS  read-only: bit0 TX FIFO not full, bit1 RX valid, bit2 RX overrun
//   other       reads 0, writes ignored
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   mode   in   [3:0] access request, 0 = none, mode[3] = 1 write / 0 read
//   addr   in   [31:0] offset within the window, only [3:0] decoded
//   wdata  in   [31:0] write data, only [7:0] used
//   rdata  out  [31:0] combinational read data
//   txd    out  UART transmit line, idle high, registered
//   rxd    in   UART receive line, asynchronous to clk
// ---------------------------------------------------------------------------
module serial_controller #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  mode,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        txd,
   input  logic        rxd
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] BIT_RELOAD  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

   // ---------------- bus decode ----------------
   logic access, wr_acc, rd_acc, sel_data, sel_status;
   logic push, pop, data_rd, rx_load;
   logic unused_bits;

   assign access      = (mode != 4'b0000);
   assign wr_acc      = access & mode[3];
   assign rd_acc      = access & ~mode[3];
   assign sel_data    = (addr[3:0] == 4'h8);
   assign sel_status  = (addr[3:0] == 4'hC);
   assign unused_bits = ^{addr[31:4], wdata[31:8]};

   // ---------------- state ----------------
   logic [7:0]  fifo_mem_q [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]  fifo_cnt_q, fifo_cnt_d;
   logic        fifo_full;

   uart_state_e tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_idx_q, tx_idx_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        txd_q, txd_d;

   logic [1:0]  rx_sync_q;
   logic        rx_s;
   uart_state_e rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_idx_q, rx_idx_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  rx_byte_q, rx_byte_d;
   logic        rx_valid_q, rx_valid_d;
   logic        rx_ovr_q, rx_ovr_d;

   assign fifo_full = (fifo_cnt_q == 3'd4);
   assign push      = wr_acc & sel_data & ~fifo_full;   // full-FIFO writes are dropped
   assign data_rd   = rd_acc & sel_data;
   assign rx_s      = rx_sync_q[1];
   assign txd       = txd_q;

   // ---------------- read mux ----------------
   always_comb begin
      rdata = '0;
      if (rd_acc) begin
         if (sel_data)        rdata = {24'b0, rx_byte_q};
         else if (sel_status) rdata = {29'b0, rx_ovr_q, rx_valid_q, ~fifo_full};
      end
   end

   // ---------------- TX FIFO pointers ----------------
   always_comb begin
      wr_ptr_d   = wr_ptr_q + 2'(push);
      rd_ptr_d   = rd_ptr_q + 2'(pop);
      fifo_cnt_d = fifo_cnt_q;
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // NOTE: FIFO storage has no reset; validity is tracked by the pointers and
   // count, so clearing those is enough and the array maps to plain RAM/flops.
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= wdata[7:0];
   end

   // ---------------- TX FSM ----------------
   // NOTE: every combinational output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      pop        = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            if (fifo_cnt_q != 3'd0) begin
               pop        = 1'b1;
               tx_shift_d = fifo_mem_q[rd_ptr_q];
               tx_cnt_d   = BIT_RELOAD;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d   = BIT_RELOAD;
               tx_idx_d   = 3'd0;
               tx_state_d = S_DATA;
            end else tx_cnt_d = tx_cnt_q - CNT_ONE;
         end
         S_DATA: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d = BIT_RELOAD;
               if (tx_idx_q == 3'd7) tx_state_d = S_STOP;
               else                  tx_idx_d   = tx_idx_q + 3'd1;
            end else tx_cnt_d = tx_cnt_q - CNT_ONE;
         end
         S_STOP: begin
            if (tx_cnt_q == '0) tx_state_d = S_IDLE;
            else                tx_cnt_d   = tx_cnt_q - CNT_ONE;
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   // Line level follows the current state; registering it delays the whole
   // waveform by one cycle without changing any bit duration.
   always_comb begin
      txd_d = 1'b1;
      case (tx_state_q)
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = tx_shift_q[tx_idx_q];
         default: txd_d = 1'b1;
      endcase
   end

   // ---------------- RX FSM ----------------
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_load    = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            if (!rx_s) begin
               rx_cnt_d   = HALF_RELOAD;
               rx_state_d = S_START;
            end
         end
         S_START: begin
            // Mid-start-bit re-check rejects short glitches.
            if (rx_cnt_q == '0) begin
               if (rx_s) rx_state_d = S_IDLE;
               else begin
                  rx_cnt_d   = BIT_RELOAD;
                  rx_idx_d   = 3'd0;
                  rx_state_d = S_DATA;
               end
            end else rx_cnt_d = rx_cnt_q - CNT_ONE;
         end
         S_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_shift_d = {rx_s, rx_shift_q[7:1]};
               rx_cnt_d   = BIT_RELOAD;
               if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
               else                  rx_idx_d   = rx_idx_q + 3'd1;
            end else rx_cnt_d = rx_cnt_q - CNT_ONE;
         end
         S_STOP: begin
            if (rx_cnt_q == '0) begin
               rx_load    = rx_s;        // framing error discards the byte
               rx_state_d = S_IDLE;
            end else rx_cnt_d = rx_cnt_q - CNT_ONE;
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   // Holding register: a load beats a same-edge DATA read.
   always_comb begin
      rx_byte_d  = rx_byte_q;
      rx_valid_d = rx_valid_q;
      rx_ovr_d   = rx_ovr_q;
      if (rx_load) begin
         rx_byte_d  = rx_shift_q;
         rx_valid_d = 1'b1;
         rx_ovr_d   = rx_ovr_q | rx_valid_q;
      end else if (data_rd) begin
         rx_valid_d = 1'b0;
         rx_ovr_d   = 1'b0;
      end
   end

   // ---------------- state registers ----------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
         fifo_cnt_q <= 3'd0;
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= 3'd0;
         tx_shift_q <= 8'd0;
         txd_q      <= 1'b1;
         rx_sync_q  <= 2'b11;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= 3'd0;
         rx_shift_q <= 8'd0;
         rx_byte_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         rx_sync_q  <= {rx_sync_q[0], rxd};
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end

endmodule

// File: tb/tb_serial_controller.sv
// ---------------------------------------------------------------------------
// tb_serial_controller
//
// Bench for serial_controller at DIV = 16 (CLK_FREQ 16, BAUD 1). A table of
// register-map vectors covers reset state and address decode; hand-written
// sequences cover TX waveform/latency, FIFO overflow, RX reception, overrun,
// glitch and framing-error rejection, and reset mid-frame. A txd monitor
// decodes every frame and compares it against a queue of expected bytes
// pushed when the writes are driven.
// ---------------------------------------------------------------------------
module tb_serial_controller;

   localparam int CLK_FREQ = 16;
   localparam int BAUD     = 1;
   localparam int DIV      = CLK_FREQ / BAUD;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  mode;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        txd;
   logic        rxd;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] tx_exp [$];
   bit         tx_abort = 1'b0;

   typedef struct {
      string       name;
      logic [3:0]  mode;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      bit          chk;
   } vec_t;

   always #5 clk = ~clk;

   serial_controller #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk   (clk),
      .rst   (rst),
      .mode  (mode),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .txd   (txd),
      .rxd   (rxd)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
      mode  = 4'b1111;
      addr  = a;
      wdata = {24'hDEADBE, d};
      tick();
      mode  = 4'b0000;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      mode = 4'b0011;
      addr = a;
      #1;
      d = rdata;
      tick();
      mode = 4'b0000;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      repeat (DIV) tick();
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (DIV) tick();
      end
      rxd = stop_bit;
      repeat (DIV) tick();
      rxd = 1'b1;
   endtask

   // txd frame decoder / scoreboard consumer
   always begin
      logic [7:0] b;
      @(negedge clk);
      if (txd === 1'b0) begin
         repeat (DIV / 2 - 1) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = txd;
         end
         repeat (DIV) @(negedge clk);
         if (tx_abort) begin
            tx_abort = 1'b0;
         end else begin
            check("tx_stop_bit", {31'b0, txd}, 32'h1);
            if (tx_exp.size() == 0) check("tx_unexpected_frame", {24'b0, b}, 32'hFFFF_FFFF);
            else                    check("tx_byte", {24'b0, b}, {24'b0, tx_exp.pop_front()});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [13];
      logic [31:0] rd;
      logic [7:0]  burst [6];
      logic [7:0]  a5;
      int          nmis, first_bad, lows;

      rst   = 1'b1;
      mode  = 4'b0000;
      addr  = '0;
      wdata = '0;
      rxd   = 1'b1;
      repeat (3) tick();
      check("reset_txd", {31'b0, txd}, 32'h1);
      rst = 1'b0;
      tick();

      // ------------- register map vectors -------------
      vecs[0]  = '{"rst_status",        4'b0001, 32'h0000_000C, 32'h0,  32'h1, 1'b1};
      vecs[1]  = '{"rst_data",          4'b0001, 32'h0000_0008, 32'h0,  32'h0, 1'b1};
      vecs[2]  = '{"rd_off0",           4'b0001, 32'h0000_0000, 32'h0,  32'h0, 1'b1};
      vecs[3]  = '{"rd_off4",           4'b0010, 32'h0000_0004, 32'h0,  32'h0, 1'b1};
      vecs[4]  = '{"rd_offF",           4'b0001, 32'h0000_000F, 32'h0,  32'h0, 1'b1};
      vecs[5]  = '{"status_upper_addr", 4'b0001, 32'hBFD0_03FC, 32'h0,  32'h1, 1'b1};
      vecs[6]  = '{"wr_off0",           4'b1111, 32'h0000_0000, 32'hFF, 32'h0, 1'b0};
      vecs[7]  = '{"wr_off4",           4'b1001, 32'h0000_0004, 32'h12, 32'h0, 1'b0};
      vecs[8]  = '{"wr_status",         4'b1111, 32'h0000_000C, 32'h00, 32'h0, 1'b0};
      vecs[9]  = '{"status_after_wr",   4'b0111, 32'h0000_000C, 32'h0,  32'h1, 1'b1};
      vecs[10] = '{"data_after_wr",     4'b0001, 32'h0000_0008, 32'h0,  32'h0, 1'b1};
      vecs[11] = '{"wr_off9",           4'b1111, 32'h0000_0009, 32'h33, 32'h0, 1'b0};
      vecs[12] = '{"status_near_miss",  4'b0001, 32'h0000_000C, 32'h0,  32'h1, 1'b1};

      for (int i = 0; i < 13; i++) begin
         mode  = vecs[i].mode;
         addr  = vecs[i].addr;
         wdata = vecs[i].wdata;
         #1;
         if (vecs[i].chk) check(vecs[i].name, rdata, vecs[i].exp);
         tick();
         mode = 4'b0000;
      end
      repeat (5) tick();
      check("txd_idle_after_table", {31'b0, txd}, 32'h1);

      // ------------- single byte: exact waveform and latency -------------
      a5    = 8'hA5;
      mode  = 4'b1111;
      addr  = 32'h8;
      wdata = {24'h0, a5};
      tx_exp.push_back(a5);
      tick();                         // edge N: push
      mode = 4'b0000;
      check("a5_txd_after_n", {31'b0, txd}, 32'h1);
      tick();                         // edge N+1: pop
      check("a5_txd_after_n1", {31'b0, txd}, 32'h1);
      nmis      = 0;
      first_bad = -1;
      for (int k = 0; k < 10 * DIV; k++) begin
         logic exp_bit;
         int   bit_no;
         tick();                      // edge N+2+k
         bit_no = k / DIV;
         if (bit_no == 0)      exp_bit = 1'b0;
         else if (bit_no == 9) exp_bit = 1'b1;
         else                  exp_bit = a5[bit_no - 1];
         if (txd !== exp_bit) begin
            nmis++;
            if (first_bad < 0) first_bad = k;
         end
      end
      check("a5_waveform_mismatches", nmis, 0);
      if (first_bad >= 0) $display("  first waveform deviation at cycle %0d after edge N+2", first_bad);
      tick();
      check("a5_idle_after_frame", {31'b0, txd}, 32'h1);
      repeat (2 * DIV) tick();

      // ------------- six back-to-back writes, sixth dropped -------------
      burst = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3};
      for (int i = 0; i < 6; i++) begin
         mode  = 4'b1111;
         addr  = 32'h8;
         wdata = {24'h0, burst[i]};
         if (i < 5) tx_exp.push_back(burst[i]);
         tick();
      end
      mode = 4'b0000;
      bus_read(32'hC, rd);
      check("status_fifo_full", rd, 32'h0);
      for (int c = 0; c < 6 * 10 * DIV + 100 && tx_exp.size() != 0; c++) tick();
      check("burst_drained", tx_exp.size(), 0);
      repeat (DIV) tick();
      bus_read(32'hC, rd);
      check("status_after_drain", rd, 32'h1);

      // ------------- RX single byte -------------
      send_rx(8'h3C, 1'b1);
      repeat (4) tick();
      bus_read(32'hC, rd);
      check("rx_status_valid", rd, 32'h3);
      bus_read(32'h8, rd);
      check("rx_data_3c", rd, 32'h3C);
      bus_read(32'hC, rd);
      check("rx_status_cleared", rd, 32'h1);

      // ------------- RX overrun -------------
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      repeat (4) tick();
      bus_read(32'hC, rd);
      check("rx_status_overrun", rd, 32'h7);
      bus_read(32'h8, rd);
      check("rx_data_22", rd, 32'h22);
      bus_read(32'hC, rd);
      check("rx_status_after_ovr_read", rd, 32'h1);
      bus_read(32'h8, rd);
      check("rx_data_held", rd, 32'h22);

      // ------------- RX glitch -------------
      rxd = 1'b0;
      repeat (4) tick();
      rxd = 1'b1;
      repeat (12 * DIV) tick();
      bus_read(32'hC, rd);
      check("glitch_status", rd, 32'h1);
      bus_read(32'h8, rd);
      check("glitch_data", rd, 32'h22);

      // ------------- RX framing error -------------
      send_rx(8'h77, 1'b0);
      repeat (2 * DIV) tick();
      bus_read(32'hC, rd);
      check("frame_err_status", rd, 32'h1);
      bus_read(32'h8, rd);
      check("frame_err_data", rd, 32'h22);

      // ------------- reset mid TX frame -------------
      bus_write(32'h8, 8'h96);
      bus_write(32'h8, 8'h0F);
      bus_write(32'h8, 8'hF0);
      repeat (5 * DIV) tick();
      tx_abort = 1'b1;
      rst = 1'b1;
      tick();
      check("rst_mid_frame_txd", {31'b0, txd}, 32'h1);
      rst = 1'b0;
      bus_read(32'hC, rd);
      check("rst_status", rd, 32'h1);
      bus_read(32'h8, rd);
      check("rst_rx_byte_cleared", rd, 32'h0);
      lows = 0;
      for (int c = 0; c < 12 * DIV; c++) begin
         tick();
         if (txd !== 1'b1) lows++;
      end
      check("rst_fifo_discarded_no_tx", lows, 0);
      check("final_tx_queue_empty", tx_exp.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
